// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed scan driver for a common-anode 7-segment display
//
// Purpose:
//   Scans DIGITS digits one per slot of SCAN_DIV clocks. The inputs are latched
//   once per frame, so the display never shows a mix of two values. Segments,
//   anodes and the decimal point are active-low. Supports leading-zero
//   blanking, per-digit enable and a dark guard interval at the start of every
//   slot to suppress ghosting.
//
// Ports:
//   clk      in   1         system clock, rising edge
//   rst_n    in   1         asynchronous active-low reset
//   data_i   in   4*DIGITS  packed digits, digit i = data_i[4i+3:4i], digit 0 rightmost
//   dp_i     in   DIGITS    1 = light decimal point of digit i
//   en_i     in   DIGITS    1 = digit i enabled
//   lzb_i    in   1         1 = blank leading zeros
//   an_o     out  DIGITS    anode select, active-low, at most one bit low
//   seg_o    out  7         segments {g,f,e,d,c,b,a}, active-low
//   dp_o     out  1         decimal point, active-low
//   frame_o  out  1         one-cycle pulse when the scan wraps back to digit 0
//
// Configuration:
//   SEG7_HEX_EN  defined: codes 10..15 shown as hex A b C d E F.
//                undefined: codes 10..15 all shown as 'E'.

module seg7_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     en_i,
  input  logic                  lzb_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  load_pending;
  logic [4*DIGITS-1:0]   snap_data;
  logic [DIGITS-1:0]     snap_dp;
  logic [DIGITS-1:0]     snap_en;
  logic                  snap_lzb;

  logic                  slot_end;
  logic                  frame_end;
  logic [DIGITS-1:0]     upper_zero;
  logic [3:0]            cur_digit;
  logic                  in_guard;
  logic                  dark;
  logic [DIGITS-1:0]     an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
`ifdef SEG7_HEX_EN
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
`endif
      default: s = 7'h06;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // upper_zero[i]: snapshot digits DIGITS-1 down to i are all exactly zero.
  // Codes 10..15 are nonzero, so an invalid digit stops the blanking.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (snap_data[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (snap_data[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_digit = snap_data[4*idx +: 4];
    in_guard  = (int'(cnt) < GUARD);
    // Digit 0 is never blanked as a leading zero, so a zero value still shows "0".
    dark      = !snap_en[idx] || (snap_lzb && (idx != '0) && upper_zero[idx]);

    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!in_guard && !dark) begin
      an_nxt  = ~(DIGITS'(1) << idx);
      seg_nxt = decode(cur_digit);
      dp_nxt  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      snap_data    <= '0;
      snap_dp      <= '0;
      snap_en      <= '0;
      snap_lzb     <= 1'b0;
      an_o         <= '1;
      seg_o        <= 7'h7F;
      dp_o         <= 1'b1;
      frame_o      <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      frame_o      <= frame_end;
      load_pending <= 1'b0;
      // Latch on the first edge after reset and at each wrap to digit 0 so a
      // whole frame is drawn from one consistent set of inputs.
      if (load_pending || frame_end) begin
        snap_data <= data_i;
        snap_dp   <= dp_i;
        snap_en   <= en_i;
        snap_lzb  <= lzb_i;
      end
      an_o  <= an_nxt;
      seg_o <= seg_nxt;
      dp_o  <= dp_nxt;
    end
  end

endmodule
